// File: rtl/accel_poll_sequencer.sv
// -----------------------------------------------------------------------------
// accel_poll_sequencer
//   Periodic read sequencer for the DE2 I2C controller. Polls the
//   accelerometer X, Y, Z data registers in order, retries failed
//   transactions, and publishes one coherent three-axis sample per frame.
//
// Ports
//   i_clock        : single clock, shared with the I2C controller
//   i_reset        : asynchronous, active-high reset
//   i_enable       : polling enable
//   i_stop         : controller transaction-complete flag
//   i_ack          : controller error flag (1 = slave did not ACK)
//   i_accel_in     : controller read data
//   o_go           : controller start, high for the whole transaction
//   o_i2c_data     : {SLAVE_ADDR, sub-address}
//   o_x/y/z_out    : last published sample
//   o_sample_valid : one-cycle pulse when X/Y/Z update
//   o_axis_err     : one-cycle pulse when a frame is abandoned
//   o_err_count    : abandoned-frame count, saturating at 255
//   o_busy         : high while a transaction is armed, running or checked
// -----------------------------------------------------------------------------
module accel_poll_sequencer #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h1D,
  parameter logic [7:0]  REG_X      = 8'h06,
  parameter logic [7:0]  REG_Y      = 8'h07,
  parameter logic [7:0]  REG_Z      = 8'h08,
  parameter int unsigned POLL_DIV   = 1000,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_stop,
  input  logic        i_ack,
  input  logic [7:0]  i_accel_in,
  output logic        o_go,
  output logic [14:0] o_i2c_data,
  output logic [7:0]  o_x_out,
  output logic [7:0]  o_y_out,
  output logic [7:0]  o_z_out,
  output logic        o_sample_valid,
  output logic        o_axis_err,
  output logic [7:0]  o_err_count,
  output logic        o_busy
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] POLL_LOAD   = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TMR_LAST    = TW'(TIMEOUT - 1);
  localparam logic [3:0]    MAX_RETRY_C = 4'(MAX_RETRY);
  localparam logic [1:0]    AX_X = 2'd0;
  localparam logic [1:0]    AX_Y = 2'd1;
  localparam logic [1:0]    AX_Z = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ARM, S_RUN, S_CHECK} state_t;

  function automatic logic [7:0] sub_addr(input logic [1:0] axis);
    logic [7:0] addr;
    case (axis)
      AX_X:    addr = REG_X;
      AX_Y:    addr = REG_Y;
      AX_Z:    addr = REG_Z;
      default: addr = REG_X;
    endcase
    return addr;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_axis, w_axis_nxt;
  logic [3:0]    r_retry, w_retry_nxt;
  logic [PW-1:0] r_poll, w_poll_nxt;
  logic [1:0]    r_arm, w_arm_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic          r_stop_q;
  logic          r_drain, w_drain_nxt;
  logic [7:0]    r_shx, w_shx_nxt;
  logic [7:0]    r_shy, w_shy_nxt;
  logic          r_go, w_go_nxt;
  logic [14:0]   r_data, w_data_nxt;
  logic [7:0]    r_x, w_x_nxt;
  logic [7:0]    r_y, w_y_nxt;
  logic [7:0]    r_z, w_z_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_err, w_err_nxt;
  logic [7:0]    r_err_count, w_err_count_nxt;
  logic          r_busy, w_busy_nxt;
  logic          w_rise, w_busy_state, w_drain_req, w_fail, w_frame_end;

  // STOP edge detect; stop_q resets high so a STOP already high is no rise.
  assign w_rise       = i_stop & ~r_stop_q;
  assign w_busy_state = (r_state == S_ARM) || (r_state == S_RUN) || (r_state == S_CHECK);
  // An ENABLE drop mid-frame is remembered so the frame finishes, then idles.
  assign w_drain_req  = r_drain | (w_busy_state & ~i_enable);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_axis_nxt      = r_axis;
    w_retry_nxt     = r_retry;
    w_poll_nxt      = r_poll;
    w_arm_nxt       = r_arm;
    w_tmr_nxt       = r_tmr;
    w_drain_nxt     = w_drain_req;
    w_shx_nxt       = r_shx;
    w_shy_nxt       = r_shy;
    w_data_nxt      = r_data;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_z_nxt         = r_z;
    w_valid_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_count_nxt = r_err_count;
    w_fail          = 1'b0;
    w_frame_end     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_enable) begin
          w_state_nxt = S_WAIT;
          w_poll_nxt  = POLL_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_poll == '0) begin
          w_state_nxt = S_ARM;
          w_axis_nxt  = AX_X;
          w_retry_nxt = 4'd0;
          w_arm_nxt   = 2'd0;
          w_data_nxt  = {SLAVE_ADDR, sub_addr(AX_X)};
        end else begin
          w_poll_nxt = r_poll - PW'(1);
        end
      end
      S_ARM: begin
        // Four GO-low cycles let the controller clear and drop STOP.
        if (r_arm == 2'd3) begin
          w_state_nxt = S_RUN;
          w_tmr_nxt   = '0;
        end else begin
          w_arm_nxt = r_arm + 2'd1;
        end
      end
      S_RUN: begin
        if (w_rise) begin
          w_state_nxt = S_CHECK;
        end else if (r_tmr == TMR_LAST) begin
          w_fail = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + TW'(1);
        end
      end
      S_CHECK: begin
        if (!i_ack) begin
          w_retry_nxt = 4'd0;
          if (r_axis == AX_Z) begin
            // Z is taken straight from the bus so all three update together.
            w_x_nxt     = r_shx;
            w_y_nxt     = r_shy;
            w_z_nxt     = i_accel_in;
            w_valid_nxt = 1'b1;
            w_frame_end = 1'b1;
          end else begin
            if (r_axis == AX_X) begin
              w_shx_nxt = i_accel_in;
            end else begin
              w_shy_nxt = i_accel_in;
            end
            w_axis_nxt  = r_axis + 2'd1;
            w_state_nxt = S_ARM;
            w_arm_nxt   = 2'd0;
            w_data_nxt  = {SLAVE_ADDR, sub_addr(r_axis + 2'd1)};
          end
        end else begin
          w_fail = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Timeout or NACK: retry the same axis, or abandon the frame.
    if (w_fail) begin
      if (r_retry < MAX_RETRY_C) begin
        w_retry_nxt = r_retry + 4'd1;
        w_state_nxt = S_ARM;
        w_arm_nxt   = 2'd0;
      end else begin
        w_err_nxt   = 1'b1;
        w_frame_end = 1'b1;
        if (r_err_count != 8'hFF) begin
          w_err_count_nxt = r_err_count + 8'd1;
        end else begin
          w_err_count_nxt = r_err_count;
        end
      end
    end else begin
      w_err_nxt = 1'b0;
    end

    if (w_frame_end) begin
      w_drain_nxt = 1'b0;
      if (w_drain_req) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_WAIT;
        w_poll_nxt  = POLL_LOAD;
      end
    end else begin
      w_drain_nxt = w_drain_req;
    end

    // GO/BUSY are registered from the next state so they align with it.
    w_go_nxt   = (w_state_nxt == S_RUN) || (w_state_nxt == S_CHECK);
    w_busy_nxt = (w_state_nxt == S_ARM) || w_go_nxt;
  end

  // State and output registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_axis      <= AX_X;
      r_retry     <= 4'd0;
      r_poll      <= '0;
      r_arm       <= 2'd0;
      r_tmr       <= '0;
      r_stop_q    <= 1'b1;
      r_drain     <= 1'b0;
      r_shx       <= 8'd0;
      r_shy       <= 8'd0;
      r_go        <= 1'b0;
      r_data      <= 15'd0;
      r_x         <= 8'd0;
      r_y         <= 8'd0;
      r_z         <= 8'd0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_axis      <= w_axis_nxt;
      r_retry     <= w_retry_nxt;
      r_poll      <= w_poll_nxt;
      r_arm       <= w_arm_nxt;
      r_tmr       <= w_tmr_nxt;
      r_stop_q    <= i_stop;
      r_drain     <= w_drain_nxt;
      r_shx       <= w_shx_nxt;
      r_shy       <= w_shy_nxt;
      r_go        <= w_go_nxt;
      r_data      <= w_data_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_z         <= w_z_nxt;
      r_valid     <= w_valid_nxt;
      r_err       <= w_err_nxt;
      r_err_count <= w_err_count_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_go           = r_go;
  assign o_i2c_data     = r_data;
  assign o_x_out        = r_x;
  assign o_y_out        = r_y;
  assign o_z_out        = r_z;
  assign o_sample_valid = r_valid;
  assign o_axis_err     = r_err;
  assign o_err_count    = r_err_count;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Bench for accel_poll_sequencer: a small controller/slave model answers each
// GO with STOP after a fixed latency; a vector table drives whole frames and
// hand-written sequences cover reset, ENABLE drop and counter saturation.
module tb_accel_poll_sequencer;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst, enable, stop, ack;
  logic [7:0]  accel_in;
  logic        go, sample_valid, axis_err, busy;
  logic [14:0] i2c_data;
  logic [7:0]  x_out, y_out, z_out, err_count;

  always #5 clk = ~clk;

  accel_poll_sequencer #(.POLL_DIV(4), .TIMEOUT(64), .MAX_RETRY(3)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(enable), .i_stop(stop), .i_ack(ack),
    .i_accel_in(accel_in), .o_go(go), .o_i2c_data(i2c_data), .o_x_out(x_out),
    .o_y_out(y_out), .o_z_out(z_out), .o_sample_valid(sample_valid),
    .o_axis_err(axis_err), .o_err_count(err_count), .o_busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave / controller model ----------------
  logic [7:0] dval [3];
  int nack_y_left = 0;
  bit nack_x_all = 1'b0, nack_z_all = 1'b0, hang = 1'b0;

  initial begin
    int run_cnt;
    stop = 1'b0; ack = 1'b0; accel_in = 8'h00; run_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!go) begin
        stop = 1'b0; run_cnt = 0;
      end else if (!hang) begin
        run_cnt++;
        if (run_cnt == LAT) begin
          case (i2c_data[7:0])
            8'h06: begin ack = nack_x_all; accel_in = nack_x_all ? 8'hEE : dval[0]; end
            8'h07: begin
              if (nack_y_left > 0) begin ack = 1'b1; accel_in = 8'hEE; nack_y_left--; end
              else begin ack = 1'b0; accel_in = dval[1]; end
            end
            8'h08: begin ack = nack_z_all; accel_in = nack_z_all ? 8'hEE : dval[2]; end
            default: begin ack = 1'b1; accel_in = 8'hEE; end
          endcase
          stop = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int att [3];
  int go_len = 0, go_len_max = 0, low_len = 100;
  int valid_pulses = 0, err_pulses = 0, coincide = 0, outchg_bad = 0, go_low_bad = 0;
  logic [14:0] seq_buf [3];
  int seq_n = 0;

  initial begin
    logic prev_go;
    logic [7:0] px, py, pz;
    prev_go = 1'b0; px = 8'h00; py = 8'h00; pz = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_go = 1'b0; low_len = 100; px = 8'h00; py = 8'h00; pz = 8'h00;
      end else begin
        if (go && !prev_go) begin
          if (low_len < 4) go_low_bad++;
          low_len = 0;
          go_len = 0;
          if (i2c_data[7:0] >= 8'h06 && i2c_data[7:0] <= 8'h08) att[i2c_data[7:0] - 8'h06]++;
          if (seq_n < 3) seq_buf[seq_n] = i2c_data;
          seq_n++;
        end
        if (go) begin
          go_len++;
          if (go_len > go_len_max) go_len_max = go_len;
        end else begin
          low_len++;
        end
        if (sample_valid) valid_pulses++;
        if (axis_err) err_pulses++;
        if (sample_valid && axis_err) coincide++;
        if (!sample_valid && (x_out != px || y_out != py || z_out != pz)) outchg_bad++;
        px = x_out; py = y_out; pz = z_out; prev_go = go;
      end
    end
  end

  task automatic clear_stats();
    att[0] = 0; att[1] = 0; att[2] = 0;
    go_len_max = 0; seq_n = 0;
  endtask

  task automatic wait_event(input int bound, output bit gv, output bit ge);
    gv = 1'b0; ge = 1'b0;
    for (int n = 0; n < bound && !gv && !ge; n++) begin
      @(negedge clk);
      gv = sample_valid; ge = axis_err;
    end
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] dx, dy, dz;
    int         ny;
    bit         nx, nz, hg;
    bit         evalid;
    logic [7:0] ex, ey, ez, ecnt;
    int         ax, ay, az;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit gv, ge, found;
    int v0, e0, n, gocnt;
    logic [14:0] exp_seq [3];

    vecs[0] = '{8'h12, 8'h34, 8'h56, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 8'h56, 8'd0, 1, 1, 1};
    vecs[1] = '{8'hA5, 8'h5A, 8'hFF, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h5A, 8'hFF, 8'd0, 1, 2, 1};
    vecs[2] = '{8'h01, 8'h02, 8'h03, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h5A, 8'hFF, 8'd1, 1, 1, 4};
    vecs[3] = '{8'h00, 8'h80, 8'h7F, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h80, 8'h7F, 8'd1, 1, 4, 1};
    vecs[4] = '{8'h11, 8'h22, 8'h33, 4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 8'h7F, 8'd2, 1, 4, 0};
    vecs[5] = '{8'h44, 8'h55, 8'h66, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 8'h7F, 8'd3, 4, 0, 0};
    vecs[6] = '{8'hC3, 8'h3C, 8'h99, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 8'h3C, 8'h99, 8'd3, 1, 1, 1};
    exp_seq[0] = {7'h1D, 8'h06};
    exp_seq[1] = {7'h1D, 8'h07};
    exp_seq[2] = {7'h1D, 8'h08};

    rst = 1'b1; enable = 1'b0;
    dval[0] = 8'h00; dval[1] = 8'h00; dval[2] = 8'h00;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go", go, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", i2c_data, 15'd0);
    chk("rst_xyz", {x_out, y_out, z_out}, 24'd0);
    chk("rst_pulses", {sample_valid, axis_err}, 2'b00);
    chk("rst_errcnt", err_count, 8'd0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("disabled_idle", {go, busy}, 2'b00);

    // ---- table-driven frames ----
    for (int i = 0; i < 7; i++) begin
      dval[0] = vecs[i].dx; dval[1] = vecs[i].dy; dval[2] = vecs[i].dz;
      nack_y_left = vecs[i].ny; nack_x_all = vecs[i].nx;
      nack_z_all = vecs[i].nz; hang = vecs[i].hg;
      clear_stats();
      v0 = valid_pulses; e0 = err_pulses;
      enable = 1'b1;
      wait_event(1000, gv, ge);
      chk($sformatf("v%0d_event", i), {gv, ge}, {vecs[i].evalid, ~vecs[i].evalid});
      chk($sformatf("v%0d_xyz", i), {x_out, y_out, z_out}, {vecs[i].ex, vecs[i].ey, vecs[i].ez});
      chk($sformatf("v%0d_errcnt", i), err_count, vecs[i].ecnt);
      chk($sformatf("v%0d_att", i), {att[0][7:0], att[1][7:0], att[2][7:0]},
          {vecs[i].ax[7:0], vecs[i].ay[7:0], vecs[i].az[7:0]});
      chk($sformatf("v%0d_valid_n", i), valid_pulses - v0, vecs[i].evalid ? 1 : 0);
      chk($sformatf("v%0d_err_n", i), err_pulses - e0, vecs[i].evalid ? 0 : 1);
      if (i == 0) begin
        chk("v0_seq_n", seq_n, 3);
        for (int k = 0; k < 3; k++) chk($sformatf("v0_seq%0d", k), seq_buf[k], exp_seq[k]);
      end
      if (i == 5) chk("v5_run_len", go_len_max, 64);
    end
    hang = 1'b0;

    // ---- reset in the middle of a Y transaction ----
    dval[0] = 8'h9A; dval[1] = 8'hBC; dval[2] = 8'hDE;
    found = 1'b0;
    for (int n2 = 0; n2 < 300 && !found; n2++) begin
      @(negedge clk);
      found = go && (i2c_data[7:0] == 8'h07);
    end
    chk("rstmid_found", found, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_go", go, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_outs", {x_out, y_out, z_out, err_count, i2c_data}, 47'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    found = 1'b0;
    for (int n2 = 0; n2 < 100 && !found; n2++) begin
      @(negedge clk);
      found = go;
    end
    chk("rstmid_restart", found, 1'b1);
    chk("rstmid_first_axis", i2c_data[7:0], 8'h06);
    wait_event(1000, gv, ge);
    chk("rstmid_event", {gv, ge}, 2'b10);
    chk("rstmid_xyz", {x_out, y_out, z_out}, 24'h9ABCDE);

    // ---- ENABLE dropped during ARM of Y ----
    dval[0] = 8'h21; dval[1] = 8'h43; dval[2] = 8'h65;
    found = 1'b0;
    for (int n2 = 0; n2 < 300 && !found; n2++) begin
      @(negedge clk);
      found = busy && !go && (i2c_data[7:0] == 8'h07);
    end
    chk("endrop_found", found, 1'b1);
    enable = 1'b0;
    wait_event(1000, gv, ge);
    chk("endrop_event", {gv, ge}, 2'b10);
    chk("endrop_xyz", {x_out, y_out, z_out}, 24'h214365);
    gocnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (go || busy) gocnt++;
    end
    chk("endrop_quiet", gocnt, 0);

    // ---- forced failures until ERR_COUNT saturates ----
    nack_x_all = 1'b1;
    v0 = valid_pulses; e0 = err_pulses; gocnt = 0;
    enable = 1'b1;
    for (int f = 1; f <= 300; f++) begin
      wait_event(1000, gv, ge);
      if (!ge || gv) gocnt++;
      if (f == 1) begin
        chk("sat_cnt1", err_count, 8'd1);
        n = 0; found = 1'b0;
        while (n < 100 && !found) begin
          @(negedge clk);
          n++;
          found = go;
        end
        chk("next_frame_gap", n, 8);
      end
      if (f == 254) chk("sat_cnt254", err_count, 8'hFE);
      if (f == 255) chk("sat_cnt255", err_count, 8'hFF);
    end
    chk("sat_bad_events", gocnt, 0);
    chk("sat_cnt300", err_count, 8'hFF);
    chk("sat_err_pulses", err_pulses - e0, 300);
    chk("sat_no_valid", valid_pulses - v0, 0);
    chk("sat_xyz_kept", {x_out, y_out, z_out}, 24'h214365);

    chk("never_coincide", coincide, 0);
    chk("out_change_only_on_valid", outchg_bad, 0);
    chk("go_low_min4", go_low_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accel_poll_sequencer.md
# accel_poll_sequencer

Periodic read sequencer that sits directly upstream of the DE2 I2C controller. It drives the controller's GO and I2C_DATA inputs and consumes its STOP, ACK and 8-bit read data. It polls the accelerometer's X, Y and Z data registers in order and publishes one coherent three-axis sample per frame, retrying failed transactions. Downstream logic uses X_OUT/Y_OUT/Z_OUT qualified by SAMPLE_VALID.

## Interface
- SLAVE_ADDR, 7'h1D, 7-bit I2C slave address placed in I2C_DATA[14:8]
- REG_X, 8'h06, sub-address of X data register
- REG_Y, 8'h07, sub-address of Y data register
- REG_Z, 8'h08, sub-address of Z data register
- POLL_DIV, 1000, idle cycles between frames (>=1)
- TIMEOUT, 64, max RUN cycles waiting for STOP rise (>=48)
- MAX_RETRY, 3, retries per axis before the frame is abandoned (0..15)

- CLOCK  in  1  single clock; same clock as the I2C controller
- RESET  in  1  asynchronous, active-high reset
- ENABLE  in  1  polling enable
- STOP  in  1  controller transaction-complete flag
- ACK  in  1  controller error flag (1 = missing slave ACK)
- ACCEL_IN  in  8  controller read data
- GO  out  1  controller start; held high for the whole transaction
- I2C_DATA  out  15  {SLAVE_ADDR, sub-address}
- X_OUT, Y_OUT, Z_OUT  out  8 each  last published sample
- SAMPLE_VALID  out  1  one-cycle pulse when X/Y/Z update
- AXIS_ERR  out  1  one-cycle pulse when a frame is abandoned
- ERR_COUNT  out  8  abandoned-frame count, saturates at 255
- BUSY  out  1  high in ARM, RUN, CHECK

## Operation
- Reset: all outputs 0; state IDLE; axis=X; retry=0; shadow regs 0; internal stop_q=1.
- States: IDLE, WAIT, ARM, RUN, CHECK.
- IDLE: GO=0. ENABLE=1 -> WAIT with poll counter loaded to POLL_DIV-1.
- WAIT: counter decrements; at 0 -> ARM with axis=X, retry=0. If ENABLE=0 at any WAIT cycle -> IDLE.
- ARM: GO=0; I2C_DATA={SLAVE_ADDR, REG[axis]}; lasts exactly 4 cycles (guarantees the controller counter clears and STOP drops), then -> RUN.
- RUN: GO=1, I2C_DATA stable; RUN timer counts from 0. stop_q registers STOP every cycle; rise = STOP & ~stop_q. rise -> CHECK. Timer reaching TIMEOUT-1 without rise -> failure path.
- CHECK (1 cycle, GO=1): if ACK=0, shadow[axis] <= ACCEL_IN, retry <= 0. If axis was Z: X/Y/Z_OUT <= shadows together, SAMPLE_VALID pulse, -> WAIT (or IDLE if ENABLE=0). Otherwise axis advances -> ARM. If ACK=1: failure path.
- Failure path: retry < MAX_RETRY -> retry+1, ARM on same axis. Otherwise AXIS_ERR pulse, ERR_COUNT+1 (saturating), outputs X/Y/Z unchanged, shadows discarded, -> WAIT/IDLE as above.
- ENABLE deassert during ARM/RUN/CHECK: frame completes (including retries), then IDLE.
- X/Y/Z_OUT never change except on the SAMPLE_VALID cycle; partial frames are never published.

## Timing
- All state/outputs registered on posedge CLOCK; RESET clears asynchronously at any time, including mid-transaction (GO drops immediately).
- GO falls on the cycle after CHECK or timeout; min GO-low width 4 cycles.
- CHECK occurs 1 cycle after STOP is seen high at the port (stop_q delay); ACK/ACCEL_IN sampled in CHECK.
- SAMPLE_VALID and outputs update on the same edge; AXIS_ERR and SAMPLE_VALID never coincide.
- Error-free frame with the companion controller: 3 x (4 ARM + ~44 RUN + 1 CHECK) cycles; frame period = POLL_DIV + frame length.
- STOP high at reset does not count as a rise (stop_q resets to 1).

## Test plan
- Reset then ENABLE=1, POLL_DIV=4, slave returns X=8'h12, Y=8'h34, Z=8'h56 -> after one frame X_OUT=12, Y_OUT=34, Z_OUT=56, one SAMPLE_VALID pulse, ERR_COUNT=0; I2C_DATA shows {1D,06},{1D,07},{1D,08} in order.
- Slave NACKs Y once -> Y re-read (extra ARM/RUN), sample published with correct values, AXIS_ERR never pulses.
- Slave NACKs Z every attempt, MAX_RETRY=3 -> 4 Z attempts, AXIS_ERR pulse, ERR_COUNT=1, X/Y/Z_OUT retain previous sample, next frame starts after POLL_DIV.
- STOP held low (hung controller), TIMEOUT=64 -> each RUN ends after 64 cycles, retries exhausted, AXIS_ERR pulse; 300 forced failures -> ERR_COUNT saturates at 8'hFF.
- RESET asserted mid-RUN on axis Y -> GO=0 and all outputs 0 within the same cycle; after release with ENABLE=1, fresh frame starts at axis X.
- ENABLE dropped during ARM of Y -> frame completes and publishes, then IDLE; no further GO assertion while ENABLE=0.
